ram1_access_arbiter: RTL
========================

// Module: ram1_access_arbiter
// PURPOSE
//  Shares the single RAM1/serial memory controller between the IF stage (instruction fetch) and the MEM stage (data load/store) of the pipelined CPU.
//  Grants at most one access per CLK cycle. Muxes the winner's address, data and op codes onto the controller. Stalls the loser.
//  Sits between the pipeline stages and the memory controller; the hazard unit consumes if_stall/mem_stall.
// PARAMETERS
//  AW       16  address width (controller address bus)
//  DW       16  data width
//  MAX_RUN   3  consecutive MEM grants before IF is forced a slot (only with ARB_FAIR_EN)
// PORTS
//  CLK          in   1   system clock; all state updates on posedge
//  RST          in   1   reset, synchronous, active-low
//  if_req       in   1   IF wants a fetch this cycle
//  if_addr      in   AW  fetch address (PC)
//  if_instr     out  DW  fetched instruction (live when granted, else held copy)
//  if_stall     out  1   IF not granted this cycle; freeze PC and IF/ID
//  mem_read     in   2   MEM read op (00 none, 01/10 read, 11 illegal)
//  mem_write    in   2   MEM write op (same encoding)
//  mem_addr     in   AW  data address (includes 0xBF00 data / 0xBF01 status)
//  mem_wdata    in   DW  store data
//  mem_rdata    out DW   load data (live when granted)
//  mem_stall    out  1   MEM not granted this cycle; freeze EX/MEM and earlier stages
//  ctl_addr     out  AW  to controller address
//  ctl_wdata    out  DW  to controller dataIn
//  ctl_read     out  2   to controller memRead
//  ctl_write    out  2   to controller memWrite
//  ctl_rdata    in   DW  from controller dataOut
//  arb_state    out  2   current FSM state (debug)
//  proto_err    out  1   sticky: illegal MEM op seen
// BEHAVIOUR
//  - mem_valid = (mem_read in {01,10} & mem_write==00) | (mem_write in {01,10} & mem_read==00). Any other non-zero combination is illegal: treated as no request, sets proto_err on the next edge.
//  - FSM states: IDLE=0, FETCH=1, DATA=2. arb_state holds the state registered at the last edge.
//  - Next state is DATA if mem_valid & !force_if. Else FETCH if if_req. Else IDLE.
//  - Grant is combinational from the same-cycle requests (same rule), so an access completes in the cycle it is granted: 0-cycle latency, data valid before the next posedge.
//  - Grant MEM: ctl_* = mem_*; mem_rdata = ctl_rdata; if_stall = if_req.
//  - Grant IF: ctl_addr = if_addr, ctl_read = 01, ctl_write = 00, ctl_wdata = 0; if_stall = 0.
//  - No grant: ctl_read = ctl_write = 00, ctl_addr = 0, ctl_wdata = 0.
//  - if_instr register loads ctl_rdata at each posedge with an IF grant. While stalled, if_instr shows the held value.
//  - mem_stall = mem_valid & !mem_grant. It is non-zero only when forced by ARB_FAIR_EN.
//  - Simultaneous IF and MEM requests: MEM wins (older instruction).
//  - Back-to-back MEM grants keep IF stalled indefinitely, unless ARB_FAIR_EN is defined.
//  - While RST=0: all ctl_* ops = 00, if_stall = mem_stall = 0, mem_rdata = 0. Registers load on the edge: state IDLE, if_instr 0, run counter 0, proto_err 0.
//  - Reset asserted mid-access aborts the access at that edge. There is no retry.
// CONFIGURATION
//  ARB_FAIR_EN defined:
//  - 2-bit run counter counts consecutive MEM grants while if_req=1. It clears on an IF grant or when if_req=0.
//  - When the count reaches MAX_RUN, force_if=1: the next contended cycle grants IF and asserts mem_stall.
//  - Counter saturates; it never wraps.
//  ARB_FAIR_EN undefined: force_if tied 0, counter absent, mem_stall constant 0.
// STRUCTURE
//  - Package mem_arb_pkg: state enum (IDLE/FETCH/DATA), OP_NONE=2'b00, OP_RD=2'b01, OP_WR=2'b01, UART_DATA=16'hBF00, UART_STAT=16'hBF01.
//  - One sub-module, mem_arb_run_ctr: saturating run counter producing force_if. Instantiated only under ARB_FAIR_EN.
// TESTING
//  1. RST=0 for 2 cycles with if_req=1, mem_read=01 -> ctl_read=00, ctl_write=00, stalls 0. After release: arb_state=IDLE→grant, proto_err=0.
//  2. if_req=1, if_addr=0x0010, ctl_rdata=0x6A05 -> ctl_read=01, ctl_addr=0x0010, if_stall=0. if_instr=0x6A05 after the edge.
//  3. if_req=1, mem_write=01, mem_addr=0xBF00, mem_wdata=0x0041 -> ctl_write=01, ctl_addr=0xBF00, ctl_wdata=0x0041, if_stall=1. if_instr unchanged.
//  4. mem_read=11, if_req=1 -> IF granted, mem treated as idle. proto_err=1 after the edge and stays 1 until RST.
//  5. ARB_FAIR_EN, MAX_RUN=3, if_req=1, mem_read=01 held 5 cycles -> MEM, MEM, MEM, IF (mem_stall=1), MEM.
//  6. RST driven 0 during a MEM write cycle -> ctl_write=00 in that cycle, state IDLE, if_instr=0 after the edge.

Source files
------------

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : mem_arb_pkg                                                      |
// | Shared state encoding and op/address constants for the RAM1 arbiter.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DATA  = 2'd2
  } arb_state_t;

  localparam logic [1:0]  OP_NONE   = 2'b00;
  localparam logic [1:0]  OP_RD     = 2'b01;
  localparam logic [1:0]  OP_WR     = 2'b01;
  localparam logic [15:0] UART_DATA = 16'hBF00;
  localparam logic [15:0] UART_STAT = 16'hBF01;

  // Both 01 and 10 name a real access; 11 is illegal.
  function automatic logic op_active(input logic [1:0] op);
    return (op == 2'b01) || (op == 2'b10);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arb_run_ctr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : mem_arb_run_ctr                                                  |
// | Saturating count of consecutive MEM wins over a waiting IF; forces IF in.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mem_arb_run_ctr #(
  parameter int MAX_RUN = 3
) (
  input  logic CLK,
  input  logic RST,
  input  logic if_req,
  input  logic if_grant,
  input  logic mem_grant,
  output logic force_if
);

  localparam logic [1:0] c_max_run = 2'(MAX_RUN);

  logic [1:0] r_count;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_count <= 2'd0;
    end else if (if_grant || !if_req) begin
      r_count <= 2'd0;
    end else if (mem_grant && (r_count < c_max_run)) begin
      r_count <= r_count + 2'd1;
    end
  end

  // Only meaningful when IF is actually contending this cycle.
  assign force_if = if_req && (r_count >= c_max_run);

endmodule
`default_nettype wire

// File: rtl/ram1_access_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : ram1_access_arbiter                                              |
// | Shares the RAM1 controller between IF and MEM; MEM wins ties. Define       |
// | ARB_FAIR_EN to bound consecutive MEM wins to MAX_RUN while IF waits.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ram1_access_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int MAX_RUN = 3
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_instr,
  output logic          if_stall,
  input  logic [1:0]    mem_read,
  input  logic [1:0]    mem_write,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_wdata,
  output logic [DW-1:0] mem_rdata,
  output logic          mem_stall,
  output logic [AW-1:0] ctl_addr,
  output logic [DW-1:0] ctl_wdata,
  output logic [1:0]    ctl_read,
  output logic [1:0]    ctl_write,
  input  logic [DW-1:0] ctl_rdata,
  output logic [1:0]    arb_state,
  output logic          proto_err
);

  logic          w_mem_valid;
  logic          w_mem_illegal;
  logic          w_force_if;
  logic          w_mem_grant;
  logic          w_if_grant;
  arb_state_t    r_state;
  logic [DW-1:0] r_if_instr;
  logic          r_proto_err;

  assign w_mem_valid   = (op_active(mem_read)  && (mem_write == OP_NONE)) ||
                         (op_active(mem_write) && (mem_read  == OP_NONE));
  assign w_mem_illegal = ((mem_read | mem_write) != OP_NONE) && !w_mem_valid;

`ifdef ARB_FAIR_EN
  mem_arb_run_ctr #(
    .MAX_RUN (MAX_RUN)
  ) u_run_ctr (
    .CLK       (CLK),
    .RST       (RST),
    .if_req    (if_req),
    .if_grant  (w_if_grant),
    .mem_grant (w_mem_grant),
    .force_if  (w_force_if)
  );
  assign mem_stall = RST && w_mem_valid && !w_mem_grant;
`else
  logic w_unused_max_run;
  assign w_unused_max_run = (MAX_RUN == 0);
  assign w_force_if       = 1'b0;
  assign mem_stall        = 1'b0;
`endif

  // Grants are decided from this cycle's requests so the access finishes in-cycle.
  assign w_mem_grant = RST && w_mem_valid && !w_force_if;
  assign w_if_grant  = RST && if_req && !w_mem_grant;

  always_comb begin
    ctl_addr  = '0;
    ctl_wdata = '0;
    ctl_read  = OP_NONE;
    ctl_write = OP_NONE;
    if (w_mem_grant) begin
      ctl_addr  = mem_addr;
      ctl_wdata = mem_wdata;
      ctl_read  = mem_read;
      ctl_write = mem_write;
    end else if (w_if_grant) begin
      ctl_addr  = if_addr;
      ctl_read  = OP_RD;
    end
  end

  assign mem_rdata = w_mem_grant ? ctl_rdata : '0;
  assign if_instr  = w_if_grant  ? ctl_rdata : r_if_instr;
  assign if_stall  = RST && if_req && !w_if_grant;
  assign arb_state = r_state;
  assign proto_err = r_proto_err;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state     <= ST_IDLE;
      r_if_instr  <= '0;
      r_proto_err <= 1'b0;
    end else begin
      if (w_mem_grant) begin
        r_state <= ST_DATA;
      end else if (w_if_grant) begin
        r_state <= ST_FETCH;
      end else begin
        r_state <= ST_IDLE;
      end
      if (w_if_grant) begin
        r_if_instr <= ctl_rdata;
      end
      if (w_mem_illegal) begin
        r_proto_err <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
